// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file writeback slice.
//   DATA_W        register / result width
//   ADDR_W        register address width (instruction field width)
//   NREGS         implemented registers; addresses >= NREGS are illegal
//   WB_FIFO_DEPTH default result queue depth (power of 2, >= 2)
//   WB_INIT/WB_RUN writeback controller state encoding
//   wb_entry_t    one queued register write {addr, data}
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 5;
  localparam int NREGS         = 16;
  localparam int WB_FIFO_DEPTH = 2;

  localparam logic [0:0] WB_INIT = 1'b0;
  localparam logic [0:0] WB_RUN  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // The address field is wider than the implemented register count, so
  // every destination coming from the pipeline has to be range-checked.
  function automatic logic addrLegal(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NREGS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding pending register writes.
//   clk_i       clock, all state on rising edge
//   rst_ni      asynchronous active-low reset (contents discarded)
//   push_i      write pushData_i (caller guarantees !full_o)
//   pushData_i  entry to enqueue
//   pop_i       drop the head entry (caller guarantees !empty_o)
//   popData_o   current head entry
//   count_o     number of entries held
//   full_o      DEPTH entries held
//   empty_o     no entries held
// ---------------------------------------------------------------------------
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  wb_entry_t              pushData_i,
  input  logic                   pop_i,
  output wb_entry_t              popData_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally and the extra count bit distinguishes full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= pushData_i;
  end

  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
// Writer-side controller for the 16 x 32 register file and the sole driver
// of Waddr/Writedata/RegWr. After reset it sweeps zero into every register,
// then merges ALU and load results through a small queue into one write per
// cycle, and keeps a pending-write scoreboard for decode hazard checks.
//   CLK/RESET                 clock, asynchronous active-low reset
//   AluValid/AluReady/AluAddr/AluData  ALU result handshake
//   LdValid/LdReady/LdAddr/LdData      load result handshake (has priority)
//   ResvValid/ResvAddr        decode reserves a destination register
//   WbStall                   register-file port busy, hold writes
//   Pending                   bit i = write to register i outstanding
//   InitDone                  zero sweep complete
//   AddrErr                   1-cycle pulse: illegal destination dropped
//   Waddr/Writedata/RegWr     registered register-file write port
// ---------------------------------------------------------------------------
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluAddr,
  input  logic [DATA_W-1:0] AluData,
  input  logic              LdValid,
  output logic              LdReady,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  input  logic              ResvValid,
  input  logic [ADDR_W-1:0] ResvAddr,
  input  logic              WbStall,
  output logic [NREGS-1:0]  Pending,
  output logic              InitDone,
  output logic              AddrErr,
  output logic [ADDR_W-1:0] Waddr,
  output logic [DATA_W-1:0] Writedata,
  output logic              RegWr
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] sweepCnt_q, sweepCnt_d;
  logic              regWr_q, regWr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              initDone_q, initDone_d;
  logic              addrErr_q, addrErr_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  logic                       isRun;
  logic                       ldFire;
  logic                       aluFire;
  logic                       accepted;
  wb_entry_t                  inEntry;
  logic                       inLegal;
  logic                       popHead;
  logic                       bypass;
  logic                       pushFifo;
  wb_entry_t                  fifoHead;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic                       fifoFull;
  logic                       fifoEmpty;

  assign isRun = (state_q == WB_RUN);

  // Readiness only looks at the current occupancy, never at a same-cycle
  // pop, which keeps the ready path free of the stall/drain logic.
  assign LdReady  = isRun && !fifoFull;
  assign AluReady = isRun && !fifoFull && !LdValid;
  assign ldFire   = LdValid && LdReady;
  assign aluFire  = AluValid && AluReady;
  assign accepted = ldFire || aluFire;

  // Select the single result accepted this cycle; load wins over ALU.
  always_comb begin
    inEntry = '{addr: AluAddr, data: AluData};
    if (ldFire) inEntry = '{addr: LdAddr, data: LdData};
  end

  assign inLegal = addrLegal(inEntry.addr);

  // Drain from the queue when it holds something; otherwise a fresh legal
  // result skips the queue so it reaches the write port one cycle later.
  assign popHead  = isRun && !WbStall && !fifoEmpty;
  assign bypass   = isRun && !WbStall && (fifoCount == '0) && accepted && inLegal;
  assign pushFifo = accepted && inLegal && !bypass;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .push_i     (pushFifo),
    .pushData_i (inEntry),
    .pop_i      (popHead),
    .popData_o  (fifoHead),
    .count_o    (fifoCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // Next-state for the sweep and the write port. The sweep counter runs one
  // past the last register so the final zero write completes before RUN.
  always_comb begin
    state_d    = state_q;
    sweepCnt_d = sweepCnt_q;
    regWr_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    initDone_d = initDone_q;
    addrErr_d  = 1'b0;
    if (state_q == WB_INIT) begin
      if (sweepCnt_q < ADDR_W'(NREGS)) begin
        regWr_d    = 1'b1;
        waddr_d    = sweepCnt_q;
        wdata_d    = '0;
        sweepCnt_d = sweepCnt_q + ADDR_W'(1);
      end else begin
        state_d    = WB_RUN;
        initDone_d = 1'b1;
      end
    end else begin
      addrErr_d = accepted && !inLegal;
      if (popHead) begin
        regWr_d = 1'b1;
        waddr_d = fifoHead.addr;
        wdata_d = fifoHead.data;
      end else if (bypass) begin
        regWr_d = 1'b1;
        waddr_d = inEntry.addr;
        wdata_d = inEntry.data;
      end
    end
  end

  // Scoreboard: a completed write clears its bit, a reservation sets it,
  // and applying the set last lets it win when both hit the same register.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NREGS; i++) begin
      if (regWr_q && (waddr_q == ADDR_W'(i))) pending_d[i] = 1'b0;
      if (isRun && ResvValid && (ResvAddr == ADDR_W'(i))) pending_d[i] = 1'b1;
    end
  end

  // All controller state; reset restarts the sweep from register 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= WB_INIT;
      sweepCnt_q <= '0;
      regWr_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      initDone_q <= 1'b0;
      addrErr_q  <= 1'b0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
      regWr_q    <= regWr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      initDone_q <= initDone_d;
      addrErr_q  <= addrErr_d;
      pending_q  <= pending_d;
    end
  end

  assign RegWr     = regWr_q;
  assign Waddr     = waddr_q;
  assign Writedata = wdata_q;
  assign InitDone  = initDone_q;
  assign AddrErr   = addrErr_q;
  assign Pending   = pending_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
// Scoreboard bench for regfile_writeback: every accepted legal result is
// queued as an expected write, and a monitor pops the queue whenever the
// DUT asserts RegWr, so write order and data are checked independently of
// the stimulus. Directed sequences cover sweep, priority, stall, scoreboard
// and reset behaviour; a random phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } expWrite_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AluValid = 1'b0;
  logic        AluReady;
  logic [4:0]  AluAddr = '0;
  logic [31:0] AluData = '0;
  logic        LdValid = 1'b0;
  logic        LdReady;
  logic [4:0]  LdAddr = '0;
  logic [31:0] LdData = '0;
  logic        ResvValid = 1'b0;
  logic [4:0]  ResvAddr = '0;
  logic        WbStall = 1'b0;
  logic [15:0] Pending;
  logic        InitDone;
  logic        AddrErr;
  logic [4:0]  Waddr;
  logic [31:0] Writedata;
  logic        RegWr;

  expWrite_t sbQ[$];
  int  checkCount = 0;
  int  failCount = 0;
  bit  monOn = 1'b0;
  bit  runPhase = 1'b0;
  bit  expAddrErr = 1'b0;
  logic sampLdReady;
  logic sampAluReady;

  regfile_writeback dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .AluValid  (AluValid),
    .AluReady  (AluReady),
    .AluAddr   (AluAddr),
    .AluData   (AluData),
    .LdValid   (LdValid),
    .LdReady   (LdReady),
    .LdAddr    (LdAddr),
    .LdData    (LdData),
    .ResvValid (ResvValid),
    .ResvAddr  (ResvAddr),
    .WbStall   (WbStall),
    .Pending   (Pending),
    .InitDone  (InitDone),
    .AddrErr   (AddrErr),
    .Waddr     (Waddr),
    .Writedata (Writedata),
    .RegWr     (RegWr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  // One comparison: counts it, reports it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, records the handshakes
  // seen just before the rising edge, and after that edge turns every legal
  // accepted result into an expected write (illegal ones into an AddrErr).
  task automatic applyStimulus(input logic aluV, input logic [4:0] aluA,
                               input logic [31:0] aluD, input logic ldV,
                               input logic [4:0] ldA, input logic [31:0] ldD,
                               input logic resvV, input logic [4:0] resvA,
                               input logic stall);
    logic aluAcc, ldAcc, err;
    @(negedge CLK);
    AluValid = aluV; AluAddr = aluA; AluData = aluD;
    LdValid = ldV; LdAddr = ldA; LdData = ldD;
    ResvValid = resvV; ResvAddr = resvA; WbStall = stall;
    #1;
    sampLdReady = LdReady;
    sampAluReady = AluReady;
    aluAcc = AluValid && AluReady;
    ldAcc = LdValid && LdReady;
    if (runPhase && LdValid) checkOutput("AluReady while load valid", AluReady, 1'b0);
    if (runPhase && !LdValid) checkOutput("AluReady equals LdReady", AluReady, LdReady);
    @(posedge CLK);
    #1;
    err = 1'b0;
    if (ldAcc) begin
      if (ldA < 5'd16) sbQ.push_back('{addr: ldA, data: ldD});
      else err = 1'b1;
    end
    if (aluAcc) begin
      if (aluA < 5'd16) sbQ.push_back('{addr: aluA, data: aluD});
      else err = 1'b1;
    end
    expAddrErr = err;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Asserts reset, checks the cleared outputs, releases it and follows the
  // zero sweep to the first RUN cycle.
  task automatic resetAndSweep();
    monOn = 1'b0;
    runPhase = 1'b0;
    expAddrErr = 1'b0;
    sbQ.delete();
    AluValid = 1'b1; LdValid = 1'b1; ResvValid = 1'b0; WbStall = 1'b0;
    RESET = 1'b0;
    #1;
    checkOutput("reset RegWr", RegWr, 1'b0);
    checkOutput("reset Waddr", Waddr, 5'd0);
    checkOutput("reset Writedata", Writedata, 32'd0);
    checkOutput("reset Pending", Pending, 16'd0);
    checkOutput("reset InitDone", InitDone, 1'b0);
    checkOutput("reset AddrErr", AddrErr, 1'b0);
    checkOutput("reset LdReady", LdReady, 1'b0);
    checkOutput("reset AluReady", AluReady, 1'b0);
    @(posedge CLK);
    AluValid = 1'b0; LdValid = 1'b0;
    for (int i = 0; i < 16; i++) sbQ.push_back('{addr: 5'(i), data: 32'd0});
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    monOn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idleCycle();
      checkOutput("sweep RegWr", RegWr, 1'b1);
      checkOutput("sweep Waddr", Waddr, 5'(i));
      checkOutput("sweep Writedata", Writedata, 32'd0);
      checkOutput("sweep InitDone", InitDone, 1'b0);
      checkOutput("sweep LdReady", LdReady, 1'b0);
    end
    idleCycle();
    checkOutput("post-sweep InitDone", InitDone, 1'b1);
    checkOutput("post-sweep RegWr", RegWr, 1'b0);
    checkOutput("post-sweep LdReady", LdReady, 1'b1);
    checkOutput("post-sweep AluReady", AluReady, 1'b1);
    runPhase = 1'b1;
  endtask

  // Monitor: every RegWr cycle must match the oldest expected write, and
  // AddrErr must follow the bench's record of dropped results.
  initial begin
    expWrite_t exp;
    forever begin
      @(negedge CLK);
      if (monOn) begin
        if (RegWr) begin
          if (sbQ.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL unexpected write: got addr %0d data 0x%0h, expected no write",
                     Waddr, Writedata);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("write address", Waddr, exp.addr);
            checkOutput("write data", Writedata, exp.data);
          end
        end
        checkOutput("AddrErr", AddrErr, expAddrErr);
      end
    end
  end

  initial begin
    int guard;

    resetAndSweep();

    // Single ALU result takes the bypass path.
    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("bypass RegWr", RegWr, 1'b1);
    checkOutput("bypass Waddr", Waddr, 5'd3);
    checkOutput("bypass Writedata", Writedata, 32'h12345678);

    // Load beats ALU; ALU goes through the following cycle.
    applyStimulus(1'b1, 5'd1, 32'd5, 1'b1, 5'd2, 32'd9, 1'b0, 5'd0, 1'b0);
    checkOutput("priority AluReady", sampAluReady, 1'b0);
    checkOutput("priority LdReady", sampLdReady, 1'b1);
    checkOutput("priority first Waddr", Waddr, 5'd2);
    applyStimulus(1'b1, 5'd1, 32'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("priority second AluReady", sampAluReady, 1'b1);
    checkOutput("priority second Waddr", Waddr, 5'd1);
    idleCycle();
    checkOutput("idle RegWr", RegWr, 1'b0);

    // Stalled loads fill the queue, third one is refused.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1);
    checkOutput("stall load1 LdReady", sampLdReady, 1'b1);
    checkOutput("stall RegWr", RegWr, 1'b0);
    checkOutput("stall Waddr hold", Waddr, 5'd1);
    checkOutput("stall Writedata hold", Writedata, 32'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 1'b1);
    checkOutput("stall load2 LdReady", sampLdReady, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b1);
    checkOutput("stall load3 LdReady", sampLdReady, 1'b0);
    checkOutput("stall full RegWr", RegWr, 1'b0);
    idleCycle();
    checkOutput("drain1 RegWr", RegWr, 1'b1);
    checkOutput("drain1 Waddr", Waddr, 5'd4);
    idleCycle();
    checkOutput("drain2 RegWr", RegWr, 1'b1);
    checkOutput("drain2 Waddr", Waddr, 5'd5);
    idleCycle();
    checkOutput("drain done RegWr", RegWr, 1'b0);

    // Scoreboard: reservation coinciding with a write to r7 survives.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
    checkOutput("reserve r7", Pending, 16'h0080);
    applyStimulus(1'b1, 5'd7, 32'hA7A7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("r7 write RegWr", RegWr, 1'b1);
    checkOutput("r7 write Waddr", Waddr, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
    checkOutput("set wins over clear", Pending, 16'h0080);
    applyStimulus(1'b1, 5'd7, 32'hB7B7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0);
    checkOutput("illegal reservation ignored", Pending, 16'h0080);
    idleCycle();
    checkOutput("r7 cleared", Pending, 16'h0000);

    // Mixed random traffic; reservations use illegal addresses only.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 19)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)),
                    1'($urandom_range(0, 3) == 0));
    end
    guard = 0;
    while (sbQ.size() != 0 && guard < 10) begin
      idleCycle();
      guard++;
    end
    idleCycle();
    checkOutput("random drain queue empty", sbQ.size(), 0);
    checkOutput("random Pending untouched", Pending, 16'h0000);

    // Illegal destination completes handshake but is dropped.
    applyStimulus(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("illegal AluReady", sampAluReady, 1'b1);
    checkOutput("illegal AddrErr", AddrErr, 1'b1);
    checkOutput("illegal RegWr", RegWr, 1'b0);
    idleCycle();
    checkOutput("AddrErr one cycle", AddrErr, 1'b0);

    // Reset with queued results: outputs clear at once, queue is lost.
    applyStimulus(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1);
    checkOutput("pre-reset Pending", Pending, 16'h0008);
    resetAndSweep();
    for (int i = 0; i < 3; i++) idleCycle();
    checkOutput("queue lost after reset", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
